// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Brief    : Shared widths, junction ids and assembler state encoding.
// Revision : 1.0
// ============================================================================
package traffic_pkg;
    localparam int WORD_W  = 32;
    localparam int FRAME_W = 1024;
    localparam int WORDS   = FRAME_W / WORD_W;
    localparam int CNT_W   = $clog2(WORDS);
    localparam int NUM_J   = 5;
    localparam int DEST_W  = 3;

    localparam logic [DEST_W-1:0] J_MID = 3'd0;
    localparam logic [DEST_W-1:0] J_L   = 3'd1;
    localparam logic [DEST_W-1:0] J_R   = 3'd2;
    localparam logic [DEST_W-1:0] J_T   = 3'd3;
    localparam logic [DEST_W-1:0] J_D   = 3'd4;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } asmState_t;
endpackage
`default_nettype wire

// File: rtl/junction_holdoff.sv
`default_nettype none
// ============================================================================
// Module   : junction_holdoff
// Brief    : Per-junction saturating hold-off counter; ready when it reaches 0.
// Revision : 1.0
// ============================================================================
module junction_holdoff #(
    parameter int HOLD_CYCLES = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic ready
);
    localparam int c_CNT_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

    logic [c_CNT_W-1:0] r_cnt;

    // A load on the dispatch edge wins over the running decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_CNT_W'(HOLD_CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    assign ready = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/frame_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : frame_dispatcher
// Brief    : Reassembles 32-bit word streams into 1024-bit frames and routes
//            each frame to its junction image register, honouring hold-off.
// Revision : 1.0
// ============================================================================
module frame_dispatcher
    import traffic_pkg::*;
#(
    parameter int HOLD_CYCLES = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_sof,
    input  logic [DEST_W-1:0]  in_dest,
    output logic [FRAME_W-1:0] img_mid,
    output logic [FRAME_W-1:0] img_l,
    output logic [FRAME_W-1:0] img_r,
    output logic [FRAME_W-1:0] img_t,
    output logic [FRAME_W-1:0] img_d,
    output logic [NUM_J-1:0]   upd,
    output logic               err_dest,
    output logic               err_sync,
    output logic               busy
);
    asmState_t          r_state;
    logic [CNT_W-1:0]   r_wordCnt;
    logic [FRAME_W-1:0] r_asmFrame;
    logic [DEST_W-1:0]  r_asmDest;
    logic               r_pendValid;
    logic [FRAME_W-1:0] r_pendFrame;
    logic [DEST_W-1:0]  r_pendDest;
    logic [FRAME_W-1:0] r_img [NUM_J];
    logic [NUM_J-1:0]   r_upd;
    logic               r_errDest;
    logic               r_errSync;

    logic               w_xfer;
    logic               w_lastWord;
    logic               w_destOk;
    logic               w_dispatch;
    logic               w_slotFree;
    logic               w_move;
    logic [FRAME_W-1:0] w_asmNext;
    logic [NUM_J-1:0]   w_jReady;
    logic [NUM_J-1:0]   w_load;

    assign in_ready   = (r_state == COLLECT);
    assign w_xfer     = in_valid && in_ready;
    assign w_lastWord = w_xfer && !in_sof && (r_wordCnt == CNT_W'(WORDS - 1));
    assign w_destOk   = (r_asmDest < DEST_W'(NUM_J));

    always_comb begin
        w_dispatch = 1'b0;
        for (int j = 0; j < NUM_J; j++) begin
            if (r_pendDest == DEST_W'(j)) begin
                w_dispatch = r_pendValid && w_jReady[j];
            end
        end
    end

    // The slot counts as free on the very edge it dispatches.
    assign w_slotFree = !r_pendValid || w_dispatch;
    assign w_move     = (r_state == FULL) ? w_slotFree
                                          : (w_lastWord && w_destOk && w_slotFree);

    always_comb begin
        w_asmNext = r_asmFrame;
        if (in_sof) begin
            w_asmNext[FRAME_W-1 -: WORD_W] = in_data;
        end else begin
            w_asmNext[FRAME_W-1-int'(r_wordCnt)*WORD_W -: WORD_W] = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= COLLECT;
            r_wordCnt  <= '0;
            r_asmFrame <= '0;
            r_asmDest  <= '0;
            r_errSync  <= 1'b0;
            r_errDest  <= 1'b0;
        end else begin
            r_errSync <= 1'b0;
            r_errDest <= 1'b0;
            case (r_state)
                COLLECT: begin
                    if (w_xfer) begin
                        if (in_sof) begin
                            r_asmFrame <= w_asmNext;
                            r_asmDest  <= in_dest;
                            r_wordCnt  <= CNT_W'(1);
                            r_errSync  <= (r_wordCnt != '0);
                        end else if (r_wordCnt == '0) begin
                            r_errSync <= 1'b1;
                        end else if (w_lastWord) begin
                            r_asmFrame <= w_asmNext;
                            r_wordCnt  <= '0;
                            if (!w_destOk) begin
                                r_errDest <= 1'b1;
                            end else if (!w_slotFree) begin
                                r_state <= FULL;
                            end
                        end else begin
                            r_asmFrame <= w_asmNext;
                            r_wordCnt  <= r_wordCnt + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (w_slotFree) begin
                        r_state <= COLLECT;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pendValid <= 1'b0;
            r_pendFrame <= '0;
            r_pendDest  <= '0;
        end else if (w_move) begin
            r_pendValid <= 1'b1;
            r_pendFrame <= (r_state == FULL) ? r_asmFrame : w_asmNext;
            r_pendDest  <= r_asmDest;
        end else if (w_dispatch) begin
            r_pendValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd <= '0;
            for (int j = 0; j < NUM_J; j++) begin
                r_img[j] <= '0;
            end
        end else begin
            r_upd <= w_load;
            for (int j = 0; j < NUM_J; j++) begin
                if (w_load[j]) begin
                    r_img[j] <= r_pendFrame;
                end
            end
        end
    end

    for (genvar j = 0; j < NUM_J; j++) begin : g_holdoff
        assign w_load[j] = w_dispatch && (r_pendDest == DEST_W'(j));

        junction_holdoff #(
            .HOLD_CYCLES(HOLD_CYCLES)
        ) u_holdoff (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (w_load[j]),
            .ready (w_jReady[j])
        );
    end

    assign img_mid  = r_img[J_MID];
    assign img_l    = r_img[J_L];
    assign img_r    = r_img[J_R];
    assign img_t    = r_img[J_T];
    assign img_d    = r_img[J_D];
    assign upd      = r_upd;
    assign err_dest = r_errDest;
    assign err_sync = r_errSync;
    assign busy     = (r_wordCnt != '0) || (r_state == FULL) || r_pendValid;
endmodule
`default_nettype wire

// File: tb/tb_frame_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_dispatcher
// Brief    : Directed scenarios plus a randomized frame stream checked against
//            an ordered frame-list model of the dispatcher.
// Revision : 1.0
// ============================================================================
module tb_frame_dispatcher;
    localparam int HOLD = 80;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof   = 1'b0;
    logic [31:0]   in_data  = '0;
    logic [2:0]    in_dest  = '0;
    logic          in_ready, err_dest, err_sync, busy;
    logic [1023:0] img_mid, img_l, img_r, img_t, img_d;
    logic [4:0]    upd;

    frame_dispatcher #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sof(in_sof), .in_dest(in_dest),
        .img_mid(img_mid), .img_l(img_l), .img_r(img_r), .img_t(img_t), .img_d(img_d),
        .upd(upd), .err_dest(err_dest), .err_sync(err_sync), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passCnt = 0, totalCnt = 0;
    int timeouts = 0;
    int evJ[$];
    int evCyc[$];
    logic [1023:0] evImg[$];
    int errSyncCnt = 0, errDestCnt = 0, illegalChg = 0, readyLowCnt = 0;
    logic [1023:0] prevImg [5];

    function automatic logic [1023:0] imgOf(input int j);
        case (j)
            0:       return img_mid;
            1:       return img_l;
            2:       return img_r;
            3:       return img_t;
            default: return img_d;
        endcase
    endfunction

    // Observation log: every update pulse, error pulse and image change.
    always @(negedge clk) begin
        logic [1023:0] cur;
        for (int j = 0; j < 5; j++) begin
            cur = imgOf(j);
            if (rst_n) begin
                if (upd[j]) begin
                    evJ.push_back(j);
                    evCyc.push_back(cyc);
                    evImg.push_back(cur);
                end else if (cur !== prevImg[j]) begin
                    illegalChg++;
                end
            end
            prevImg[j] = cur;
        end
        if (rst_n) begin
            if (err_sync) errSyncCnt++;
            if (err_dest) errDestCnt++;
            if (!in_ready) readyLowCnt++;
        end
    end

    task automatic clear_mon();
        evJ.delete();
        evCyc.delete();
        evImg.delete();
        errSyncCnt = 0; errDestCnt = 0; illegalChg = 0; readyLowCnt = 0; timeouts = 0;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        clear_mon();
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive_idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            in_data = $urandom;
            in_sof  = 1'($urandom);
            in_dest = 3'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic sof, input logic [2:0] dest,
                             output int acc);
        bit ok = 1'b0;
        int n = 0;
        in_valid = 1'b1; in_data = d; in_sof = sof; in_dest = dest;
        while (!ok && n < 400) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!ok) timeouts++;
        acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int dest, input logic [1023:0] f, input int maxGap,
                              output int lastAcc);
        int acc = 0;
        for (int k = 0; k < 32; k++) begin
            if (maxGap > 0) drive_idle($urandom_range(maxGap, 0));
            send_word(f[1023-32*k -: 32], (k == 0), (k == 0) ? 3'(dest) : 3'($urandom), acc);
        end
        lastAcc = acc;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin @(posedge clk); #1; n++; end
        if (busy) timeouts++;
        step(3);
    endtask

    function automatic logic [1023:0] rand_frame();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic test_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        totalCnt++;
        if ((img_mid | img_l | img_r | img_t | img_d) !== '0) $display("FAIL reset_img: images not zero during reset");
        else passCnt++;
        totalCnt++;
        if ({upd, err_dest, err_sync, busy} !== 8'b0) $display("FAIL reset_flags: got %b want 00000000", {upd, err_dest, err_sync, busy});
        else passCnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(2);
        totalCnt++;
        if ({in_ready, busy, upd} !== 7'b1000000) $display("FAIL reset_after: in_ready,busy,upd got %b want 1000000", {in_ready, busy, upd});
        else passCnt++;
    endtask

    task automatic test_single();
        logic [1023:0] f;
        int e;
        apply_reset();
        for (int k = 0; k < 32; k++) f[1023-32*k -: 32] = 32'(k + 1);
        send_frame(1, f, 0, e);
        step(4);
        totalCnt++;
        if (evJ.size() != 1 || evJ[0] != 1) $display("FAIL single_upd: %0d pulses, want exactly one on junction 1", evJ.size());
        else passCnt++;
        totalCnt++;
        if (evCyc.size() < 1 || evCyc[0] != e + 1) $display("FAIL single_latency: upd edge %0d want %0d", (evCyc.size() > 0) ? evCyc[0] : -1, e + 1);
        else passCnt++;
        totalCnt++;
        if (img_l[1023:992] !== 32'h1 || img_l[31:0] !== 32'h20) $display("FAIL single_words: first %h last %h want 00000001 00000020", img_l[1023:992], img_l[31:0]);
        else passCnt++;
        totalCnt++;
        if (img_l !== f) $display("FAIL single_img: img_l does not match the sent frame");
        else passCnt++;
        totalCnt++;
        if ((img_mid | img_r | img_t | img_d) !== '0 || illegalChg != 0) $display("FAIL single_others: other images changed (illegal changes %0d)", illegalChg);
        else passCnt++;
        totalCnt++;
        if (timeouts != 0) $display("FAIL single_timeout: %0d words never accepted", timeouts);
        else passCnt++;
    endtask

    task automatic test_holdoff();
        logic [1023:0] fa, fb, fc;
        int ea, eb, ec, d0, d1, d2;
        apply_reset();
        fa = rand_frame(); fb = rand_frame(); fc = rand_frame();
        send_frame(0, fa, 0, ea);
        send_frame(0, fb, 0, eb);
        send_frame(0, fc, 0, ec);
        wait_idle();
        d0 = ea + 1;
        d1 = (eb + 1 > d0 + HOLD + 1) ? eb + 1 : d0 + HOLD + 1;
        d2 = (ec + 1 > d1 + HOLD + 1) ? ec + 1 : d1 + HOLD + 1;
        totalCnt++;
        if (evJ.size() != 3) $display("FAIL holdoff_count: %0d updates want 3", evJ.size());
        else passCnt++;
        if (evJ.size() == 3) begin
            totalCnt++;
            if (evCyc[0] != d0 || evCyc[1] != d1 || evCyc[2] != d2)
                $display("FAIL holdoff_timing: edges %0d %0d %0d want %0d %0d %0d", evCyc[0], evCyc[1], evCyc[2], d0, d1, d2);
            else passCnt++;
            totalCnt++;
            if (evJ[0] != 0 || evJ[1] != 0 || evJ[2] != 0 || evImg[0] !== fa || evImg[1] !== fb || evImg[2] !== fc)
                $display("FAIL holdoff_data: junctions %0d %0d %0d or frame contents wrong", evJ[0], evJ[1], evJ[2]);
            else passCnt++;
        end
        totalCnt++;
        if (readyLowCnt != d1 - ec) $display("FAIL holdoff_ready: in_ready low %0d cycles want %0d", readyLowCnt, d1 - ec);
        else passCnt++;
        totalCnt++;
        if (timeouts != 0 || busy !== 1'b0) $display("FAIL holdoff_drain: timeouts %0d busy %b want 0 0", timeouts, busy);
        else passCnt++;
    endtask

    task automatic test_parallel();
        logic [1023:0] fr, fd;
        int er, ed;
        apply_reset();
        fr = rand_frame(); fd = rand_frame();
        send_frame(2, fr, 0, er);
        send_frame(4, fd, 0, ed);
        wait_idle();
        totalCnt++;
        if (evJ.size() != 2 || evJ[0] != 2 || evJ[1] != 4) $display("FAIL parallel_order: %0d updates, want junction 2 then 4", evJ.size());
        else passCnt++;
        totalCnt++;
        if (evCyc.size() != 2 || evCyc[0] != er + 1 || evCyc[1] != ed + 1)
            $display("FAIL parallel_timing: got %0d updates, want edges %0d %0d", evCyc.size(), er + 1, ed + 1);
        else passCnt++;
        totalCnt++;
        if (img_r !== fr || img_d !== fd || illegalChg != 0) $display("FAIL parallel_img: img_r/img_d wrong or illegal changes %0d", illegalChg);
        else passCnt++;
    endtask

    task automatic test_errors();
        logic [1023:0] f1, f2, f3;
        int acc, e;
        apply_reset();
        send_word(32'hDEAD_BEEF, 1'b0, 3'd1, acc);
        step(2);
        totalCnt++;
        if (errSyncCnt != 1 || busy !== 1'b0) $display("FAIL err_nosof: err_sync pulses %0d busy %b want 1 0", errSyncCnt, busy);
        else passCnt++;
        f1 = rand_frame(); f2 = rand_frame(); f3 = rand_frame();
        for (int k = 0; k < 10; k++) send_word(f1[1023-32*k -: 32], (k == 0), 3'd1, acc);
        send_frame(0, f2, 0, e);
        wait_idle();
        totalCnt++;
        if (errSyncCnt != 2) $display("FAIL err_restart: err_sync pulses %0d want 2", errSyncCnt);
        else passCnt++;
        totalCnt++;
        if (evJ.size() != 1 || evJ[0] != 0 || img_mid !== f2 || img_l !== '0)
            $display("FAIL err_restart_data: %0d updates, want only restarted frame on junction 0", evJ.size());
        else passCnt++;
        send_frame(6, f3, 0, e);
        wait_idle();
        totalCnt++;
        if (errDestCnt != 1 || evJ.size() != 1 || busy !== 1'b0)
            $display("FAIL err_dest: err_dest pulses %0d updates %0d busy %b want 1 1 0", errDestCnt, evJ.size(), busy);
        else passCnt++;
    endtask

    task automatic test_reset_mid();
        logic [1023:0] fa, fb, fc, ft;
        int e, acc;
        apply_reset();
        fa = rand_frame(); fb = rand_frame(); fc = rand_frame(); ft = rand_frame();
        send_frame(1, fa, 0, e);
        send_frame(1, fb, 0, e);
        for (int k = 0; k < 15; k++) send_word(fc[1023-32*k -: 32], (k == 0), 3'd2, acc);
        totalCnt++;
        if (img_l !== fa || busy !== 1'b1) $display("FAIL rstmid_before: img_l match %b busy %b want 1 1", img_l === fa, busy);
        else passCnt++;
        rst_n = 1'b0;
        #2;
        totalCnt++;
        if ((img_mid | img_l | img_r | img_t | img_d) !== '0 || {busy, in_ready, upd} !== 7'b0100000)
            $display("FAIL rstmid_async: busy,in_ready,upd got %b want 0100000 and zero images", {busy, in_ready, upd});
        else passCnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_mon();
        send_frame(3, ft, 0, e);
        wait_idle();
        totalCnt++;
        if (evJ.size() != 1 || evJ[0] != 3 || evCyc[0] != e + 1)
            $display("FAIL rstmid_next: %0d updates, want one on junction 3 at edge %0d", evJ.size(), e + 1);
        else passCnt++;
        totalCnt++;
        if (img_t !== ft || (img_mid | img_l | img_r | img_d) !== '0) $display("FAIL rstmid_img: img_t wrong or stale frame dispatched");
        else passCnt++;
    endtask

    task automatic test_random();
        int expJ[$];
        logic [1023:0] expImg[$];
        logic [1023:0] lastImg [5];
        int lastCyc [5];
        int expErr = 0, bad = 0, gapBad = 0, r, dest, e;
        logic [1023:0] f;
        apply_reset();
        for (int j = 0; j < 5; j++) begin lastImg[j] = '0; lastCyc[j] = -100000; end
        for (int n = 0; n < 14; n++) begin
            r = $urandom_range(9, 0);
            dest = (r < 7) ? $urandom_range(2, 0) : (r < 9) ? $urandom_range(4, 3) : $urandom_range(7, 5);
            f = rand_frame();
            send_frame(dest, f, 2, e);
            if (dest < 5) begin
                expJ.push_back(dest);
                expImg.push_back(f);
                lastImg[dest] = f;
            end else begin
                expErr++;
            end
            drive_idle($urandom_range(3, 0));
        end
        wait_idle();
        totalCnt++;
        if (evJ.size() != expJ.size()) $display("FAIL rand_count: %0d updates want %0d", evJ.size(), expJ.size());
        else passCnt++;
        for (int i = 0; i < evJ.size() && i < expJ.size(); i++) begin
            if (evJ[i] != expJ[i] || evImg[i] !== expImg[i]) bad++;
            if (evCyc[i] - lastCyc[evJ[i]] < HOLD + 1) gapBad++;
            lastCyc[evJ[i]] = evCyc[i];
        end
        totalCnt++;
        if (bad != 0) $display("FAIL rand_order: %0d updates with wrong junction or frame, want 0", bad);
        else passCnt++;
        totalCnt++;
        if (gapBad != 0) $display("FAIL rand_hold: %0d same-junction updates closer than %0d edges, want 0", gapBad, HOLD + 1);
        else passCnt++;
        for (int j = 0; j < 5; j++) begin
            totalCnt++;
            if (imgOf(j) !== lastImg[j]) $display("FAIL rand_final_img: junction %0d image differs from last frame sent to it", j);
            else passCnt++;
        end
        totalCnt++;
        if (errDestCnt != expErr || errSyncCnt != 0) $display("FAIL rand_errors: err_dest %0d err_sync %0d want %0d 0", errDestCnt, errSyncCnt, expErr);
        else passCnt++;
        totalCnt++;
        if (illegalChg != 0 || timeouts != 0) $display("FAIL rand_misc: illegal changes %0d timeouts %0d want 0 0", illegalChg, timeouts);
        else passCnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_holdoff();
        test_parallel();
        test_errors();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passCnt, totalCnt);
        $fatal(1);
    end
endmodule
`default_nettype wire
